// File: rtl/hazard_scoreboard_pkg.sv
// Shared core types for the hazard scoreboard: register select type,
// in-flight slot record and the bubble constant loaded on reset.
package core_pkg;

    localparam int NUM_REGS  = 8;
    localparam int REG_SEL_W = $clog2(NUM_REGS);

    typedef logic [REG_SEL_W-1:0] reg_sel_t;

    typedef struct packed {
        logic     valid;
        reg_sel_t wr1_sel;
        logic     wr1_en;
        reg_sel_t wr2_sel;
        logic     wr2_en;
        logic     halt;
    } inflight_slot_t;

    localparam inflight_slot_t SLOT_BUBBLE = '0;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode/execute side bundle of the hazard scoreboard; the core is the
// master, the scoreboard is the slave.
interface hazard_scoreboard_if;
    import core_pkg::*;

    logic        id_valid;
    reg_sel_t    id_rs1_sel;
    reg_sel_t    id_rs2_sel;
    logic        id_rs1_used;
    logic        id_rs2_used;
    reg_sel_t    id_wr1_sel;
    reg_sel_t    id_wr2_sel;
    logic        id_wr1_en;
    logic        id_wr2_en;
    logic        id_halt;
    logic        ex_branch;

    logic        stall;
    logic        flush;
    logic        halted;
    logic        fwd_rs1;
    logic        fwd_rs2;
    logic [15:0] stall_count;
    logic [3:0]  inflight;

    modport master (
        output id_valid, id_rs1_sel, id_rs2_sel, id_rs1_used, id_rs2_used,
               id_wr1_sel, id_wr2_sel, id_wr1_en, id_wr2_en, id_halt, ex_branch,
        input  stall, flush, halted, fwd_rs1, fwd_rs2, stall_count, inflight
    );

    modport slave (
        input  id_valid, id_rs1_sel, id_rs2_sel, id_rs1_used, id_rs2_used,
               id_wr1_sel, id_wr2_sel, id_wr1_en, id_wr2_en, id_halt, ex_branch,
        output stall, flush, halted, fwd_rs1, fwd_rs2, stall_count, inflight
    );

endinterface

// File: rtl/hazard_scoreboard_slot_match.sv
// Compares one decode source register against both write ports of one
// in-flight slot.
module slot_match
    import core_pkg::*;
(
    input  reg_sel_t       src_sel,
    input  logic           src_used,
    input  inflight_slot_t slot,
    output logic           hit
);

    // Select 0 is an ordinary register here, so no zero exemption.
    assign hit = src_used && slot.valid &&
                 ((slot.wr1_en && (slot.wr1_sel == src_sel)) ||
                  (slot.wr2_en && (slot.wr2_sel == src_sel)));

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW stall, branch flush stretching and sticky halt for the pipelined core.
// Optional writeback bypass selected with HAZARD_SCOREBOARD_FORWARDING_EN.
module hazard_scoreboard
    import core_pkg::*;
#(
    parameter int PIPE_DEPTH   = 2,
    parameter int FLUSH_CYCLES = 1
)
(
    input  logic         clock,
    input  logic         reset_n,
    hazard_scoreboard_if.slave sb
);

    localparam int LAST = PIPE_DEPTH - 1;

    inflight_slot_t          slot [PIPE_DEPTH];
    inflight_slot_t          id_entry;
    logic [PIPE_DEPTH-1:0]   hit_rs1;
    logic [PIPE_DEPTH-1:0]   hit_rs2;
    logic [1:0]              flush_cnt;
    logic                    halted_q;
    logic [15:0]             stall_cnt_q;
    logic                    hazard;
    logic                    stall_w;
    logic                    flush_w;
    logic                    issue;
    logic                    fwd1_w;
    logic                    fwd2_w;
    logic [3:0]              inflight_w;

    for (genvar i = 0; i < PIPE_DEPTH; i++) begin : g_match
        slot_match u_rs1 (
            .src_sel  (sb.id_rs1_sel),
            .src_used (sb.id_rs1_used),
            .slot     (slot[i]),
            .hit      (hit_rs1[i])
        );
        slot_match u_rs2 (
            .src_sel  (sb.id_rs2_sel),
            .src_used (sb.id_rs2_used),
            .slot     (slot[i]),
            .hit      (hit_rs2[i])
        );
    end

`ifdef HAZARD_SCOREBOARD_FORWARDING_EN
    // Only the retiring slot can be bypassed; anything younger still stalls.
    logic young_rs1;
    logic young_rs2;

    if (PIPE_DEPTH > 1) begin : g_young
        assign young_rs1 = |hit_rs1[PIPE_DEPTH-2:0];
        assign young_rs2 = |hit_rs2[PIPE_DEPTH-2:0];
    end else begin : g_no_young
        assign young_rs1 = 1'b0;
        assign young_rs2 = 1'b0;
    end

    assign hazard = young_rs1 | young_rs2;
    assign fwd1_w = sb.id_valid & ~halted_q & hit_rs1[LAST] & ~young_rs1;
    assign fwd2_w = sb.id_valid & ~halted_q & hit_rs2[LAST] & ~young_rs2;
`else
    assign hazard = (|hit_rs1) | (|hit_rs2);
    assign fwd1_w = 1'b0;
    assign fwd2_w = 1'b0;
`endif

    assign flush_w = sb.ex_branch | (flush_cnt != 2'd0);
    assign stall_w = halted_q | (sb.id_valid & hazard & ~flush_w);
    assign issue   = sb.id_valid & ~stall_w & ~flush_w & ~halted_q;

    assign id_entry = '{valid:   1'b1,
                        wr1_sel: sb.id_wr1_sel,
                        wr1_en:  sb.id_wr1_en,
                        wr2_sel: sb.id_wr2_sel,
                        wr2_en:  sb.id_wr2_en,
                        halt:    sb.id_halt};

    always_comb begin
        inflight_w = '0;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            inflight_w = inflight_w + 4'(slot[i].valid);
        end
    end

    // Shadow pipeline, flush stretch, halt latch and stall statistics.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                slot[i] <= SLOT_BUBBLE;
            end
            flush_cnt   <= '0;
            halted_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            slot[0] <= issue ? id_entry : SLOT_BUBBLE;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                slot[i] <= slot[i-1];
            end

            if (sb.ex_branch) begin
                flush_cnt <= 2'(FLUSH_CYCLES - 1);
            end else if (flush_cnt != 2'd0) begin
                flush_cnt <= flush_cnt - 2'd1;
            end

            if (slot[LAST].valid && slot[LAST].halt) begin
                halted_q <= 1'b1;
            end

            if (stall_w && !halted_q && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign sb.stall       = stall_w;
    assign sb.flush       = flush_w;
    assign sb.halted      = halted_q;
    assign sb.fwd_rs1     = fwd1_w;
    assign sb.fwd_rs2     = fwd2_w;
    assign sb.stall_count = stall_cnt_q;
    assign sb.inflight    = inflight_w;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: vector table, reset corner case,
// randomized run against an age-based reference model, and counter saturation.
module tb_hazard_scoreboard;
    import core_pkg::*;

    localparam int D     = 3;
    localparam int F     = 2;
    localparam int SAT_D = 8;
`ifdef HAZARD_SCOREBOARD_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clock       = 1'b0;
    logic reset_n     = 1'b0;
    logic reset_sat_n = 1'b0;
    int   checks      = 0;
    int   passed      = 0;

    always #5 clock = ~clock;

    hazard_scoreboard_if bus();
    hazard_scoreboard_if sat_bus();

    hazard_scoreboard #(.PIPE_DEPTH(D), .FLUSH_CYCLES(F)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .sb      (bus)
    );

    hazard_scoreboard #(.PIPE_DEPTH(SAT_D), .FLUSH_CYCLES(1)) dut_sat (
        .clock   (clock),
        .reset_n (reset_sat_n),
        .sb      (sat_bus)
    );

    typedef struct {
        bit        rst;
        logic      v;
        logic [2:0] rs1;
        logic      u1;
        logic [2:0] wr1;
        logic      e1;
        logic      br;
        logic      hlt;
        logic      st;
        logic      fl;
        logic      fw;
        logic [3:0] inf;
        logic      hd;
        logic [15:0] cnt;
    } vec_t;

    typedef struct {
        int         ic;
        logic [2:0] w1;
        logic       e1;
        logic [2:0] w2;
        logic       e2;
        logic       h;
    } rec_t;

    vec_t vecs[$];
    rec_t inq[$];
    int   mcyc;
    int   last_br;
    bit   m_halted;
    int   m_cnt;

    function automatic vec_t mkVec(bit rst, bit v, int rs1, bit u1, int wr1, bit e1, bit br, bit hlt,
                                   bit st, bit fl, bit fw, int inf, bit hd, int cnt);
        vec_t t;
        t.rst = rst; t.v = v; t.rs1 = 3'(rs1); t.u1 = u1; t.wr1 = 3'(wr1); t.e1 = e1;
        t.br = br; t.hlt = hlt; t.st = st; t.fl = fl; t.fw = fw; t.inf = 4'(inf);
        t.hd = hd; t.cnt = 16'(cnt);
        return t;
    endfunction

    function automatic void modelReset();
        inq.delete();
        mcyc     = 0;
        last_br  = -100;
        m_halted = 1'b0;
        m_cnt    = 0;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    task automatic driveIdle();
        bus.id_valid = 1'b0; bus.id_rs1_sel = '0; bus.id_rs1_used = 1'b0;
        bus.id_rs2_sel = '0; bus.id_rs2_used = 1'b0; bus.id_wr1_sel = '0;
        bus.id_wr1_en = 1'b0; bus.id_wr2_sel = '0; bus.id_wr2_en = 1'b0;
        bus.id_halt = 1'b0; bus.ex_branch = 1'b0;
    endtask

    task automatic resetDut();
        @(negedge clock);
        reset_n = 1'b0;
        driveIdle();
        @(negedge clock);
        reset_n = 1'b1;
        modelReset();
    endtask

    task automatic applyStimulus(input vec_t t);
        @(negedge clock);
        driveIdle();
        bus.id_valid   = t.v;
        bus.id_rs1_sel = t.rs1;
        bus.id_rs1_used = t.u1;
        bus.id_wr1_sel = t.wr1;
        bus.id_wr1_en  = t.e1;
        bus.id_halt    = t.hlt;
        bus.ex_branch  = t.br;
    endtask

    task automatic checkVector(input int idx, input vec_t t);
        #1;
        checkOutput($sformatf("vec%0d_stall", idx),    16'(bus.stall),    16'(t.st));
        checkOutput($sformatf("vec%0d_flush", idx),    16'(bus.flush),    16'(t.fl));
        checkOutput($sformatf("vec%0d_fwd_rs1", idx),  16'(bus.fwd_rs1),  16'(t.fw));
        checkOutput($sformatf("vec%0d_fwd_rs2", idx),  16'(bus.fwd_rs2),  16'(1'b0));
        checkOutput($sformatf("vec%0d_inflight", idx), 16'(bus.inflight), 16'(t.inf));
        checkOutput($sformatf("vec%0d_halted", idx),   16'(bus.halted),   16'(t.hd));
        checkOutput($sformatf("vec%0d_count", idx),    bus.stall_count,   t.cnt);
    endtask

    // One randomized cycle: expectations come from the ages of issued instructions.
    task automatic randomCycle(input int idx);
        logic v, u1, u2, e1, e2, br, hl;
        logic [2:0] r1, r2, w1, w2;
        bit ym1, ym2, om1, om2, hz, exp_fl, exp_st, exp_f1, exp_f2, iss, m1, m2;
        int exp_inf, age;
        v  = ($urandom_range(3) != 0);
        r1 = 3'($urandom_range(7)); u1 = 1'($urandom_range(1));
        r2 = 3'($urandom_range(7)); u2 = 1'($urandom_range(1));
        w1 = 3'($urandom_range(7)); e1 = 1'($urandom_range(1));
        w2 = 3'($urandom_range(7)); e2 = 1'($urandom_range(1));
        br = ($urandom_range(9) == 0);
        hl = ($urandom_range(59) == 0);
        @(negedge clock);
        bus.id_valid = v; bus.id_rs1_sel = r1; bus.id_rs1_used = u1;
        bus.id_rs2_sel = r2; bus.id_rs2_used = u2; bus.id_wr1_sel = w1;
        bus.id_wr1_en = e1; bus.id_wr2_sel = w2; bus.id_wr2_en = e2;
        bus.id_halt = hl; bus.ex_branch = br;
        #1;
        exp_inf = 0; ym1 = 0; ym2 = 0; om1 = 0; om2 = 0;
        foreach (inq[k]) begin
            age = mcyc - inq[k].ic;
            m1 = u1 && ((inq[k].e1 && inq[k].w1 == r1) || (inq[k].e2 && inq[k].w2 == r1));
            m2 = u2 && ((inq[k].e1 && inq[k].w1 == r2) || (inq[k].e2 && inq[k].w2 == r2));
            exp_inf++;
            if (age == D) begin om1 |= m1; om2 |= m2; end
            else begin ym1 |= m1; ym2 |= m2; end
        end
        hz     = FWD ? (ym1 | ym2) : (ym1 | ym2 | om1 | om2);
        exp_fl = br || ((mcyc - last_br) < F);
        exp_st = m_halted || (v && hz && !exp_fl);
        exp_f1 = FWD && v && !m_halted && om1 && !ym1;
        exp_f2 = FWD && v && !m_halted && om2 && !ym2;
        iss    = v && !exp_st && !exp_fl && !m_halted;
        checkOutput($sformatf("rnd%0d_stall", idx),    16'(bus.stall),    16'(exp_st));
        checkOutput($sformatf("rnd%0d_flush", idx),    16'(bus.flush),    16'(exp_fl));
        checkOutput($sformatf("rnd%0d_halted", idx),   16'(bus.halted),   16'(m_halted));
        checkOutput($sformatf("rnd%0d_fwd_rs1", idx),  16'(bus.fwd_rs1),  16'(exp_f1));
        checkOutput($sformatf("rnd%0d_fwd_rs2", idx),  16'(bus.fwd_rs2),  16'(exp_f2));
        checkOutput($sformatf("rnd%0d_inflight", idx), 16'(bus.inflight), 16'(exp_inf));
        checkOutput($sformatf("rnd%0d_count", idx),    bus.stall_count,   16'(m_cnt));
        if (br) last_br = mcyc;
        if (exp_st && !m_halted && m_cnt < 65535) m_cnt++;
        foreach (inq[k]) begin
            if ((mcyc - inq[k].ic) == D && inq[k].h) m_halted = 1'b1;
        end
        while (inq.size() > 0 && (mcyc - inq[0].ic) >= D) void'(inq.pop_front());
        if (iss) inq.push_back('{ic: mcyc, w1: w1, e1: e1, w2: w2, e2: e2, h: hl});
        mcyc++;
    endtask

    task automatic mainTests();
        // RAW on register 3; forwarding removes the stall in the retiring slot.
        vecs.push_back(mkVec(1, 1, 0, 0, 3, 1, 0, 0,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(0, 1, 3, 1, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0));
        vecs.push_back(mkVec(0, 1, 3, 1, 0, 0, 0, 0,  1, 0, 0, 1, 0, 1));
        vecs.push_back(mkVec(0, 1, 3, 1, 0, 0, 0, 0,  !FWD, 0, FWD, 1, 0, 2));
        vecs.push_back(mkVec(0, 1, 3, 1, 0, 0, 0, 0,  0, 0, 0, FWD ? 1 : 0, 0, FWD ? 2 : 3));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, FWD ? 2 : 1, 0, FWD ? 2 : 3));
        // Register 0 is tracked like any other.
        vecs.push_back(mkVec(1, 1, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(0, 1, 0, 1, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0));
        // Branch during a hazard: two flush cycles, no stall, no issue.
        vecs.push_back(mkVec(1, 1, 0, 0, 4, 1, 0, 0,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(0, 1, 4, 1, 0, 0, 1, 0,  0, 1, 0, 1, 0, 0));
        vecs.push_back(mkVec(0, 1, 4, 1, 0, 0, 0, 0,  0, 1, 0, 1, 0, 0));
        vecs.push_back(mkVec(0, 1, 4, 1, 0, 0, 0, 0,  !FWD, 0, FWD, 1, 0, 0));
        vecs.push_back(mkVec(0, 1, 4, 1, 0, 0, 0, 0,  0, 0, 0, FWD ? 1 : 0, 0, FWD ? 0 : 1));
        // Halt retires, stall sticks, slots drain, counter frozen.
        vecs.push_back(mkVec(1, 1, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(0, 1, 0, 0, 2, 1, 0, 0,  0, 0, 0, 1, 0, 0));
        vecs.push_back(mkVec(0, 1, 0, 0, 5, 1, 0, 0,  0, 0, 0, 2, 0, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 3, 0, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 2, 1, 0));
        vecs.push_back(mkVec(0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 1, 0));
        vecs.push_back(mkVec(0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 0));
        vecs.push_back(mkVec(0, 1, 0, 0, 0, 0, 1, 0,  1, 1, 0, 0, 1, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 1, 0));

        foreach (vecs[i]) begin
            if (vecs[i].rst) resetDut();
            applyStimulus(vecs[i]);
            checkVector(i, vecs[i]);
        end

        // Asynchronous reset in the middle of a flush with two slots valid.
        resetDut();
        applyStimulus(mkVec(0, 1, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0));
        applyStimulus(mkVec(0, 1, 0, 0, 2, 1, 0, 0,  0, 0, 0, 0, 0, 0));
        applyStimulus(mkVec(0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0));
        #1;
        checkOutput("arst_pre_flush",    16'(bus.flush),    16'(1'b1));
        checkOutput("arst_pre_inflight", 16'(bus.inflight), 16'd2);
        applyStimulus(mkVec(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        #1;
        checkOutput("arst_hold_flush",   16'(bus.flush),    16'(1'b1));
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("arst_flush",    16'(bus.flush),    16'(1'b0));
        checkOutput("arst_stall",    16'(bus.stall),    16'(1'b0));
        checkOutput("arst_halted",   16'(bus.halted),   16'(1'b0));
        checkOutput("arst_inflight", 16'(bus.inflight), 16'd0);
        checkOutput("arst_count",    bus.stall_count,   16'd0);
        @(negedge clock);
        reset_n = 1'b1;
        bus.id_valid = 1'b1; bus.id_wr1_sel = 3'd6; bus.id_wr1_en = 1'b1;
        #1;
        checkOutput("arst_release_stall", 16'(bus.stall), 16'(1'b0));
        @(negedge clock);
        driveIdle();
        #1;
        checkOutput("arst_first_issue", 16'(bus.inflight), 16'd1);

        for (int chunk = 0; chunk < 3; chunk++) begin
            resetDut();
            for (int n = 0; n < 250; n++) randomCycle(chunk * 1000 + n);
        end
    endtask

    // Chained self-dependent instructions: every instruction stalls SAT_D cycles.
    task automatic satTest();
        sat_bus.id_valid = 1'b0; sat_bus.id_rs1_sel = 3'd5; sat_bus.id_rs1_used = 1'b1;
        sat_bus.id_rs2_sel = '0; sat_bus.id_rs2_used = 1'b0; sat_bus.id_wr1_sel = 3'd5;
        sat_bus.id_wr1_en = 1'b1; sat_bus.id_wr2_sel = '0; sat_bus.id_wr2_en = 1'b0;
        sat_bus.id_halt = 1'b0; sat_bus.ex_branch = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_sat_n = 1'b1;
        sat_bus.id_valid = 1'b1;
        for (int m = 1; m <= 9 * 8750 + 1; m++) begin
            @(negedge clock);
            #1;
            if (m == 9 * 1000)
                checkOutput("sat_issue_slot", 16'(sat_bus.stall), 16'(1'b0));
            if (m == 9 * 1000 + 1)
                checkOutput("sat_count_8000", sat_bus.stall_count, 16'd8000);
            if (m == 9 * 1000 + 2)
                checkOutput("sat_stall_slot", 16'(sat_bus.stall), 16'(1'b1));
            if (m == 9 * 8191 + 1)
                checkOutput("sat_count_65528", sat_bus.stall_count, 16'd65528);
            if (m == 9 * 8192 + 1)
                checkOutput("sat_count_max", sat_bus.stall_count, 16'hFFFF);
            if (m == 9 * 8192 + 3)
                checkOutput("sat_count_hold", sat_bus.stall_count, 16'hFFFF);
            if (m == 9 * 8750 + 1)
                checkOutput("sat_count_70000", sat_bus.stall_count, 16'hFFFF);
        end
    endtask

    initial begin
        driveIdle();
        modelReset();
        fork
            mainTests();
            satTest();
        join
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
